count_display_driver: RTL and testbench

Downstream consumer of the free-running 4-bit event counter. It samples the counter value, detects 15→0 wrap-around, and keeps a modulo-100 BCD wrap tally. It drives a 4-digit, common-anode, multiplexed seven-segment display: counter value as decimal 0–15 on digits 1:0, wrap tally 00–99 on digits 3:2. It shares the clock and reset of the counter it monitors.

---
 rtl/count_display_pkg.sv | 72 +++++++
 rtl/seg7_decode.sv | 39 +++
 rtl/count_display_driver.sv | 160 ++++++++++++++++
 tb/tb_count_display_driver.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/count_display_pkg.sv
// ---------------------------------------------------------------------------
// count_display_pkg
// Shared constants and helpers for the count display driver:
//   - segment patterns (active-low, bit order g..a) for BCD digits 0-9
//     and the all-off blank pattern
//   - digit-slot type and the matching active-low anode patterns
//   - default refresh divider (100 MHz clock -> 1 kHz per digit)
//   - BCD increment and slot-advance helpers
// ---------------------------------------------------------------------------
package count_display_pkg;

  localparam int REFRESH_DIV_DEFAULT = 100000;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  typedef enum logic [1:0] {
    SLOT_0 = 2'd0,
    SLOT_1 = 2'd1,
    SLOT_2 = 2'd2,
    SLOT_3 = 2'd3
  } slot_t;

  localparam logic [3:0] AN_SLOT_0 = 4'b1110;
  localparam logic [3:0] AN_SLOT_1 = 4'b1101;
  localparam logic [3:0] AN_SLOT_2 = 4'b1011;
  localparam logic [3:0] AN_SLOT_3 = 4'b0111;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Two-digit packed BCD increment, 99 rolls over to 00. Out-of-range
  // nibbles are treated as 9 so a corrupted tally recovers on the next step.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] ones;
    logic [3:0] tens;
    ones = v[3:0];
    tens = v[7:4];
    if (ones >= 4'd9) begin
      ones = 4'd0;
      if (tens >= 4'd9) begin
        tens = 4'd0;
      end else begin
        tens = tens + 4'd1;
      end
    end else begin
      ones = ones + 4'd1;
    end
    return {tens, ones};
  endfunction

  // Scan order 0 -> 1 -> 2 -> 3 -> 0.
  function automatic slot_t slot_next(input slot_t s);
    slot_t n;
    case (s)
      SLOT_0:  n = SLOT_1;
      SLOT_1:  n = SLOT_2;
      SLOT_2:  n = SLOT_3;
      SLOT_3:  n = SLOT_0;
      default: n = SLOT_0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// ---------------------------------------------------------------------------
// seg7_decode
// Combinational BCD to seven-segment decoder, active-low segments, g..a.
// Ports:
//   digit  in  4  BCD digit; values above 9 decode to blank
//   blank  in  1  force all segments off
//   seg    out 7  segment pattern, seg[0]=a ... seg[6]=g
// ---------------------------------------------------------------------------
module seg7_decode
  import count_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  // Digit lookup with blanking override.
  always_comb begin
    seg = SEG_BLANK;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/count_display_driver.sv
// ---------------------------------------------------------------------------
// count_display_driver
// Samples a free-running 4-bit counter, counts its 15->0 wrap-arounds in a
// modulo-100 BCD tally and drives a 4-digit multiplexed common-anode
// seven-segment display: counter value (0-15) on digits 1:0, tally on 3:2.
// Ports:
//   CLK         in  1  system clock
//   CLR         in  1  asynchronous active-low reset (shared with counter)
//   COUNT_IN    in  4  counter value, synchronous to CLK
//   AN          out 4  digit enables, active-low one-hot, AN[0] rightmost
//   SEG         out 7  segments, active-low, SEG[0]=a ... SEG[6]=g
//   DP          out 1  decimal point, active-low, lit in slot 2 only
//   WRAP_PULSE  out 1  one-cycle pulse per detected wrap
//   WRAPS       out 8  wrap tally, packed BCD {tens, ones}
// ---------------------------------------------------------------------------
module count_display_driver
  import count_display_pkg::*;
#(
  parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT
)
(
  input  logic       CLK,
  input  logic       CLR,
  input  logic [3:0] COUNT_IN,
  output logic [3:0] AN,
  output logic [6:0] SEG,
  output logic       DP,
  output logic       WRAP_PULSE,
  output logic [7:0] WRAPS
);

  localparam int PRE_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
  localparam logic [PRE_W-1:0] PRE_ZERO = PRE_W'(0);

  logic [3:0]       cnt_d,   cnt_q;
  logic [7:0]       wraps_d, wraps_q;
  logic             wrap_pulse_d, wrap_pulse_q;
  logic [PRE_W-1:0] pre_d,   pre_q;
  slot_t            slot_d,  slot_q;
  logic [3:0]       an_d,    an_q;
  logic [6:0]       seg_d,   seg_q;
  logic             dp_d,    dp_q;

  logic             wrap_s;
  logic             pre_last_s;
  logic [3:0]       mux_digit_s;
  logic             mux_blank_s;
  logic [6:0]       dec_seg_s;

  // Input sample, wrap detection, BCD tally and refresh prescaler.
  always_comb begin
    cnt_d        = COUNT_IN;
    wrap_s       = (cnt_q == 4'd15) && (COUNT_IN == 4'd0);
    wrap_pulse_d = wrap_s;
    pre_last_s   = (pre_q == PRE_LAST);
    if (wrap_s) begin
      wraps_d = bcd_inc(wraps_q);
    end else begin
      wraps_d = wraps_q;
    end
    if (pre_last_s) begin
      pre_d  = PRE_ZERO;
      slot_d = slot_next(slot_q);
    end else begin
      pre_d  = pre_q + PRE_ONE;
      slot_d = slot_q;
    end
  end

  // Select the digit shown in the active slot; tens of the counter is
  // either "1" or blank since the counter never exceeds 15.
  always_comb begin
    mux_digit_s = 4'd0;
    mux_blank_s = 1'b1;
    case (slot_q)
      SLOT_0: begin
        mux_digit_s = (cnt_q >= 4'd10) ? (cnt_q - 4'd10) : cnt_q;
        mux_blank_s = 1'b0;
      end
      SLOT_1: begin
        mux_digit_s = 4'd1;
        mux_blank_s = (cnt_q < 4'd10);
      end
      SLOT_2: begin
        mux_digit_s = wraps_q[3:0];
        mux_blank_s = 1'b0;
      end
      SLOT_3: begin
        mux_digit_s = wraps_q[7:4];
        mux_blank_s = 1'b0;
      end
      default: begin
        mux_digit_s = 4'd0;
        mux_blank_s = 1'b1;
      end
    endcase
  end

  seg7_decode u_seg7_decode (
    .digit (mux_digit_s),
    .blank (mux_blank_s),
    .seg   (dec_seg_s)
  );

  // Next display outputs. The last prescaler cycle of every slot turns all
  // anodes and segments off so the previous digit does not ghost into the
  // next one while the anode drivers switch.
  always_comb begin
    case (slot_q)
      SLOT_0:  an_d = AN_SLOT_0;
      SLOT_1:  an_d = AN_SLOT_1;
      SLOT_2:  an_d = AN_SLOT_2;
      SLOT_3:  an_d = AN_SLOT_3;
      default: an_d = AN_OFF;
    endcase
    if (slot_q == SLOT_2) begin
      dp_d = 1'b0;
    end else begin
      dp_d = 1'b1;
    end
    if (pre_last_s) begin
      an_d  = AN_OFF;
      seg_d = SEG_BLANK;
    end else begin
      seg_d = dec_seg_s;
    end
  end

  // All state and registered outputs.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      cnt_q        <= 4'd0;
      wraps_q      <= 8'h00;
      wrap_pulse_q <= 1'b0;
      pre_q        <= PRE_ZERO;
      slot_q       <= SLOT_0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
    end else begin
      cnt_q        <= cnt_d;
      wraps_q      <= wraps_d;
      wrap_pulse_q <= wrap_pulse_d;
      pre_q        <= pre_d;
      slot_q       <= slot_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign AN         = an_q;
  assign SEG        = seg_q;
  assign DP         = dp_q;
  assign WRAP_PULSE = wrap_pulse_q;
  assign WRAPS      = wraps_q;

endmodule

// File: tb/tb_count_display_driver.sv
// ---------------------------------------------------------------------------
// tb_count_display_driver
// Directed bench for count_display_driver with REFRESH_DIV=4. A reference
// model derives the expected outputs from the elapsed cycle count, the last
// sampled counter value and an integer wrap tally; a compare process checks
// every falling edge, and directed scenarios pin literal values.
// ---------------------------------------------------------------------------
module tb_count_display_driver;

  logic       CLK;
  logic       CLR;
  logic [3:0] COUNT_IN;
  logic [3:0] AN;
  logic [6:0] SEG;
  logic       DP;
  logic       WRAP_PULSE;
  logic [7:0] WRAPS;

  int tests = 0;
  int fails = 0;
  int pulses = 0;
  int wr = 0;

  count_display_driver #(.REFRESH_DIV(4)) dut (
    .CLK        (CLK),
    .CLR        (CLR),
    .COUNT_IN   (COUNT_IN),
    .AN         (AN),
    .SEG        (SEG),
    .DP         (DP),
    .WRAP_PULSE (WRAP_PULSE),
    .WRAPS      (WRAPS)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_cnt   = 0;
  int         m_tally = 0;
  int         m_cycle = 0;
  logic [3:0] e_an    = 4'hF;
  logic [6:0] e_seg   = 7'h7F;
  logic       e_dp    = 1'b1;
  logic       e_wp    = 1'b0;
  logic [7:0] e_wraps = 8'h00;

  always @(posedge CLK or negedge CLR) begin : model
    int slot;
    int pos;
    int dig;
    int tally_n;
    bit blank;
    bit wrap;
    if (!CLR) begin
      m_cnt   <= 0;
      m_tally <= 0;
      m_cycle <= 0;
      e_an    <= 4'hF;
      e_seg   <= 7'h7F;
      e_dp    <= 1'b1;
      e_wp    <= 1'b0;
      e_wraps <= 8'h00;
    end else begin
      slot  = (m_cycle / 4) % 4;
      pos   = m_cycle % 4;
      blank = 1'b0;
      case (slot)
        0:       dig = m_cnt % 10;
        1:       begin dig = 1; blank = (m_cnt < 10); end
        2:       dig = m_tally % 10;
        default: dig = m_tally / 10;
      endcase
      wrap    = (m_cnt == 15) && (COUNT_IN == 4'd0);
      tally_n = wrap ? (m_tally + 1) % 100 : m_tally;
      e_an    <= (pos == 3) ? 4'hF : 4'(~(4'b0001 << slot));
      e_seg   <= (pos == 3 || blank) ? 7'h7F : seg_tab[dig];
      e_dp    <= (slot == 2) ? 1'b0 : 1'b1;
      e_wp    <= wrap;
      e_wraps <= {4'(tally_n / 10), 4'(tally_n % 10)};
      m_cnt   <= int'(COUNT_IN);
      m_tally <= tally_n;
      m_cycle <= m_cycle + 1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge CLK) begin
    chk("model_an",    {4'h0, AN},         {4'h0, e_an});
    chk("model_seg",   {1'b0, SEG},        {1'b0, e_seg});
    chk("model_dp",    {7'h00, DP},        {7'h00, e_dp});
    chk("model_pulse", {7'h00, WRAP_PULSE},{7'h00, e_wp});
    chk("model_wraps", WRAPS,              e_wraps);
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(negedge CLK);
    if (WRAP_PULSE) pulses++;
  endtask

  task automatic do_wrap();
    COUNT_IN = 4'd15;
    cyc();
    COUNT_IN = 4'd0;
    cyc();
    wr++;
  endtask

  logic [3:0] an_exp [16] = '{4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hF,
                              4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7, 4'hF};
  logic [3:0] an_log  [16];
  logic [6:0] seg_log [16];
  logic       dp_log  [16];
  logic [3:0] an_log2 [8];
  logic [6:0] seg_log2[8];

  initial begin
    bit found;
    CLR      = 1'b0;
    COUNT_IN = 4'd13;

    // Reset held for three cycles.
    repeat (3) @(negedge CLK);
    chk("rst_an",    {4'h0, AN},          8'h0F);
    chk("rst_seg",   {1'b0, SEG},         8'h7F);
    chk("rst_dp",    {7'h00, DP},         8'h01);
    chk("rst_wraps", WRAPS,               8'h00);
    chk("rst_pulse", {7'h00, WRAP_PULSE}, 8'h00);
    CLR = 1'b1;

    // Scan and display with COUNT_IN=13.
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      an_log[i]  = AN;
      seg_log[i] = SEG;
      dp_log[i]  = DP;
    end
    COUNT_IN = 4'd7;
    for (int j = 0; j < 8; j++) begin
      @(negedge CLK);
      an_log2[j]  = AN;
      seg_log2[j] = SEG;
    end
    chk("first_an", {4'h0, an_log[0]}, 8'h0E);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("scan_an%0d", i), {4'h0, an_log[i]}, {4'h0, an_exp[i]});
      chk($sformatf("scan_dp%0d", i), {7'h00, dp_log[i]}, (i >= 8 && i < 12) ? 8'h00 : 8'h01);
      if (i % 4 == 3) chk($sformatf("scan_seg_off%0d", i), {1'b0, seg_log[i]}, 8'h7F);
    end
    chk("seg_first_cnt0", {1'b0, seg_log[0]}, 8'h40);
    chk("seg_13_ones",    {1'b0, seg_log[1]}, 8'h30);
    chk("seg_13_tens",    {1'b0, seg_log[5]}, 8'h79);
    chk("seg_wraps_ones", {1'b0, seg_log[9]}, 8'h40);
    chk("seg_wraps_tens", {1'b0, seg_log[13]}, 8'h40);
    chk("seg_7_ones",     {1'b0, seg_log2[1]}, 8'h78);
    chk("an_slot1_again", {4'h0, an_log2[5]}, 8'h0D);
    chk("seg_7_tens_blank", {1'b0, seg_log2[5]}, 8'h7F);

    // Single 0..15,0 sweep: exactly one pulse, one cycle after the 0.
    pulses = 0;
    for (int v = 0; v < 16; v++) begin
      COUNT_IN = 4'(v);
      cyc();
    end
    chk("no_pulse_in_sweep", 8'(pulses), 8'h00);
    COUNT_IN = 4'd0;
    cyc();
    chk("wrap_pulse_high", {7'h00, WRAP_PULSE}, 8'h01);
    chk("wraps_01",        WRAPS,               8'h01);
    wr = 1;
    cyc();
    chk("wrap_pulse_one_cycle", {7'h00, WRAP_PULSE}, 8'h00);
    COUNT_IN = 4'd15;
    cyc();
    COUNT_IN = 4'd5;
    cyc();
    COUNT_IN = 4'd0;
    cyc();
    cyc();
    chk("pulse_count_sweep", 8'(pulses), 8'h01);
    chk("wraps_still_01",    WRAPS,      8'h01);

    // BCD rollover up to 142 wraps (tally 42).
    while (wr < 142) begin
      do_wrap();
      if (wr == 9)   chk("wraps_09", WRAPS, 8'h09);
      if (wr == 100) chk("wraps_100_to_00", WRAPS, 8'h00);
      if (wr == 10) begin
        chk("wraps_10", WRAPS, 8'h10);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
          cyc();
          if (AN == 4'h7) found = 1'b1;
        end
        if (found) begin
          chk("slot3_seg_1", {1'b0, SEG}, 8'h79);
        end else begin
          chk("slot3_wait_timeout", 8'h00, 8'h01);
        end
      end
    end
    chk("wraps_42", WRAPS, 8'h42);
    chk("pulse_count_total", 8'(pulses), 8'(142));

    // Mid-run reset with 15 sampled and 0 presented.
    COUNT_IN = 4'd15;
    cyc();
    CLR      = 1'b0;
    COUNT_IN = 4'd0;
    cyc();
    cyc();
    chk("mid_rst_an",    {4'h0, AN},          8'h0F);
    chk("mid_rst_seg",   {1'b0, SEG},         8'h7F);
    chk("mid_rst_dp",    {7'h00, DP},         8'h01);
    chk("mid_rst_wraps", WRAPS,               8'h00);
    chk("mid_rst_pulse", {7'h00, WRAP_PULSE}, 8'h00);
    CLR = 1'b1;
    cyc();
    chk("post_rst_pulse", {7'h00, WRAP_PULSE}, 8'h00);
    chk("post_rst_wraps", WRAPS,               8'h00);
    chk("post_rst_an",    {4'h0, AN},          8'h0E);
    for (int v = 10; v < 16; v++) begin
      COUNT_IN = 4'(v);
      cyc();
    end
    COUNT_IN = 4'd0;
    repeat (6) cyc();
    chk("post_rst_wrap", WRAPS, 8'h01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
